pc_fp_unit: RTL and testbench
=============================

Name: pc_fp_unit

Overview:
- Sequential program-counter and frame-pointer register block directly downstream of the instruction decoder.
- Consumes the decoder's cnt_en, pc_sload, new_pc, move_fp and push_up each cycle. Produces the pc value the decoder uses for the next cycle's instruction addressing.
- Owns the boot and halt sequencing and the call/return frame pointer with bounds guarding.

Parameters:
- RESET_PC, 16'h0000, pc value loaded on reset.
- FP_BASE, 16'hFF00, fp value loaded on reset; lowest legal fp.
- FP_LIMIT, 16'hFFFF, highest legal fp.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cnt_en  input  1  from decoder: increment pc.
- pc_sload  input  1  from decoder: load pc from new_pc.
- new_pc  input  16  from decoder: pc load value.
- move_fp  input  1  from decoder: update fp this cycle.
- push_up  input  1  from decoder: fp direction when move_fp=1 (1 = +1, 0 = -1).
- stall  input  1  external hold (memory wait); freezes all state.
- pc  output  16  current program counter, to decoder.
- fp  output  16  current frame pointer, to register file / stack addressing.
- fetch_valid  output  1  high when the instruction at pc is valid for decode.
- halted  output  1  high in HALT state.
- fp_err  output  1  sticky frame-pointer bounds error.

Behaviour:
- Reset (reset=1 at a clock edge, takes priority over everything, including stall):
  - pc=RESET_PC, fp=FP_BASE, state=BOOT.
  - fetch_valid=0, halted=0, fp_err=0.
  - Reset mid-operation discards all pending updates.
- States: BOOT, RUN, HALT. fetch_valid is registered and equals 1 only in RUN. halted is 1 only in HALT.
- BOOT:
  - Exactly one cycle; gives instruction memory its 1-cycle read latency.
  - Next state is RUN unless stall=1, in which case remain in BOOT.
  - pc and fp do not change.
  - Decoder inputs are ignored.
- RUN, stall=1: pc, fp, state and fp_err all hold. Decoder inputs are ignored.
- RUN, stall=0, pc update (priority order):
  - pc_sload=1: pc <= new_pc. cnt_en is ignored.
  - else cnt_en=1: pc <= pc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000, no flag).
  - else: pc holds and the next state is HALT (stop condition: both controls low).
- RUN, stall=0, fp update (independent of the pc update, same edge):
  - move_fp=1, push_up=1: fp <= fp+1.
  - move_fp=1, push_up=0: fp <= fp-1.
  - move_fp=0: fp holds.
- HALT:
  - pc and fp frozen; all inputs except reset ignored.
  - Exit only via reset.
- Simultaneous pc_sload=1 and move_fp=1 (call/return) must both take effect on the same edge.
- Latency: a decoder control present in cycle n is visible on pc/fp in cycle n+1.

Optional Feature:
- Macro: FP_GUARD_EN.
- Defined:
  - A push with fp==FP_LIMIT, or a pop with fp==FP_BASE, leaves fp unchanged (saturates).
  - The same event sets fp_err=1; fp_err stays high until reset.
  - pc behaviour is unaffected.
- Undefined:
  - fp wraps modulo 2^16 with no bounds check.
  - fp_err is tied to 0.

Test Plan:
- Reset/boot: RESET_PC=16'h0010; assert reset 2 cycles, release with cnt_en=1 -> cycle 1: pc=0010, fetch_valid=0; cycle 2: fetch_valid=1, pc=0010; cycle 3: pc=0011.
- Jump priority: in RUN at pc=0020, drive pc_sload=1, cnt_en=1, new_pc=0105 -> next pc=0105. Then cnt_en=1 only -> pc=0106.
- Stall and wrap: pc=FFFF, cnt_en=1, stall=1 for 3 cycles -> pc stays FFFF. Stall released -> pc=0000, no error.
- Halt: cnt_en=0, pc_sload=0 at pc=0042 -> next cycle halted=1, fetch_valid=0. Then pc_sload=1, new_pc=0000 -> pc stays 0042. Reset -> halted=0, pc=RESET_PC.
- Call/return frame: fp=FF00; cycle A: pc_sload=1, new_pc=0200, move_fp=1, push_up=1 -> pc=0200, fp=FF01. Cycle B: move_fp=1, push_up=0, pc_sload=1, new_pc=0031 -> fp=FF00, pc=0031.
- Guard (FP_GUARD_EN defined): at fp=FF00, pop -> fp=FF00, fp_err=1, stays 1 after later legal pushes. Without the macro: same pop -> fp=FEFF, fp_err=0.

Source files
------------

// File: rtl/pc_fp_unit.sv
// pc_fp_unit: program-counter and frame-pointer register block that sits
// directly after the instruction decoder. Sequences BOOT -> RUN -> HALT and
// maintains the call/return frame pointer.
//
// Optional feature macro: FP_GUARD_EN
//   defined   : fp saturates at FP_BASE / FP_LIMIT and a blocked move sets
//               the sticky fp_err flag (cleared only by reset).
//   undefined : fp wraps modulo 2^16 and fp_err is tied low.
module pc_fp_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] FP_BASE  = 16'hFF00,
  parameter logic [15:0] FP_LIMIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_en,
  input  logic        pc_sload,
  input  logic [15:0] new_pc,
  input  logic        move_fp,
  input  logic        push_up,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] fp,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fp_err
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] fp_q, fp_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        halted_q, halted_d;
  logic        fp_err_q, fp_err_d;

  // Next frame pointer for a requested move; guarded builds saturate at the
  // legal window edges instead of wrapping, and report the blocked move.
  logic [15:0] fp_move_s;
  logic        fp_block_s;

  // Compute the fp value a move would produce and whether it is out of bounds.
  always_comb begin
    fp_move_s  = fp_q;
    fp_block_s = 1'b0;
    if (push_up) begin
`ifdef FP_GUARD_EN
      if (fp_q == FP_LIMIT) begin
        fp_move_s  = fp_q;
        fp_block_s = 1'b1;
      end else begin
        fp_move_s  = fp_q + 16'd1;
        fp_block_s = 1'b0;
      end
`else
      fp_move_s = fp_q + 16'd1;
`endif
    end else begin
`ifdef FP_GUARD_EN
      if (fp_q == FP_BASE) begin
        fp_move_s  = fp_q;
        fp_block_s = 1'b1;
      end else begin
        fp_move_s  = fp_q - 16'd1;
        fp_block_s = 1'b0;
      end
`else
      fp_move_s = fp_q - 16'd1;
`endif
    end
  end

  // Next-state logic for the sequencer, pc, fp and the sticky error flag.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fp_d     = fp_q;
    fp_err_d = fp_err_q;
    case (state_q)
      ST_BOOT: begin
        // One cycle to cover instruction memory read latency; decoder ignored.
        if (stall) begin
          state_d = ST_BOOT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stall) begin
          state_d = ST_RUN;
        end else begin
          // pc: jump beats increment; neither control means stop.
          if (pc_sload) begin
            pc_d = new_pc;
          end else if (cnt_en) begin
            pc_d = pc_q + 16'd1;
          end else begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end
          // fp moves independently so call/return updates both on one edge.
          if (move_fp) begin
            fp_d = fp_move_s;
            if (fp_block_s) begin
              fp_err_d = 1'b1;
            end else begin
              fp_err_d = fp_err_q;
            end
          end else begin
            fp_d = fp_q;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // Unreachable encoding: restart through BOOT.
        state_d = ST_BOOT;
      end
    endcase
`ifndef FP_GUARD_EN
    fp_err_d = 1'b0;
`endif
    fetch_valid_d = (state_d == ST_RUN);
    halted_d      = (state_d == ST_HALT);
  end

  // State register; reset wins over stall and discards pending updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fp_q          <= FP_BASE;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fp_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fp_q          <= fp_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
      fp_err_q      <= fp_err_d;
    end
  end

  assign pc          = pc_q;
  assign fp          = fp_q;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;
  assign fp_err      = fp_err_q;

endmodule

// File: tb/tb_pc_fp_unit.sv
// Directed testbench for pc_fp_unit with hand-computed expected values.
module tb_pc_fp_unit;

  logic        clk;
  logic        reset;
  logic        cnt_en;
  logic        pc_sload;
  logic [15:0] new_pc;
  logic        move_fp;
  logic        push_up;
  logic        stall;
  logic [15:0] pc;
  logic [15:0] fp;
  logic        fetch_valid;
  logic        halted;
  logic        fp_err;

  int n_vec;
  int n_err;

  logic [15:0] exp_fp;
  logic        exp_err;

  pc_fp_unit #(
    .RESET_PC (16'h0010),
    .FP_BASE  (16'hFF00),
    .FP_LIMIT (16'hFFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cnt_en      (cnt_en),
    .pc_sload    (pc_sload),
    .new_pc      (new_pc),
    .move_fp     (move_fp),
    .push_up     (push_up),
    .stall       (stall),
    .pc          (pc),
    .fp          (fp),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .fp_err      (fp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; cnt_en = 1'b0; pc_sload = 1'b0; new_pc = 16'h0000;
    move_fp = 1'b0; push_up = 1'b0; stall = 1'b0;

    // Reset for two cycles, then boot.
    step(); step();
    check("rst_pc", pc, 16'h0010);
    check("rst_fp", fp, 16'hFF00);
    check("rst_fv", {15'd0, fetch_valid}, 16'd0);
    check("rst_halt", {15'd0, halted}, 16'd0);
    check("rst_err", {15'd0, fp_err}, 16'd0);
    reset = 1'b0; cnt_en = 1'b1;
    step();
    check("boot_fv", {15'd0, fetch_valid}, 16'd1);
    check("boot_pc", pc, 16'h0010);
    step();
    check("run_inc", pc, 16'h0011);

    // Jump priority over increment.
    pc_sload = 1'b1; new_pc = 16'h0020;
    step();
    check("ld_0020", pc, 16'h0020);
    cnt_en = 1'b1; new_pc = 16'h0105;
    step();
    check("jmp_prio", pc, 16'h0105);
    pc_sload = 1'b0;
    step();
    check("inc_0106", pc, 16'h0106);

    // Stall and wrap.
    pc_sload = 1'b1; new_pc = 16'hFFFF;
    step();
    check("ld_ffff", pc, 16'hFFFF);
    pc_sload = 1'b0; stall = 1'b1; move_fp = 1'b1; push_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 16'hFFFF);
      check("stall_fp", fp, 16'hFF00);
      check("stall_fv", {15'd0, fetch_valid}, 16'd1);
    end
    stall = 1'b0; move_fp = 1'b0;
    step();
    check("wrap_pc", pc, 16'h0000);
    check("wrap_err", {15'd0, fp_err}, 16'd0);
    check("wrap_halt", {15'd0, halted}, 16'd0);

    // Call then return on the same edges as jumps.
    pc_sload = 1'b1; new_pc = 16'h0200; move_fp = 1'b1; push_up = 1'b1; cnt_en = 1'b0;
    step();
    check("call_pc", pc, 16'h0200);
    check("call_fp", fp, 16'hFF01);
    new_pc = 16'h0031; push_up = 1'b0;
    step();
    check("ret_pc", pc, 16'h0031);
    check("ret_fp", fp, 16'hFF00);

    // Pop at the base of the frame window, then a legal push.
    pc_sload = 1'b0; cnt_en = 1'b1; move_fp = 1'b1; push_up = 1'b0;
    step();
`ifdef FP_GUARD_EN
    exp_fp = 16'hFF00; exp_err = 1'b1;
`else
    exp_fp = 16'hFEFF; exp_err = 1'b0;
`endif
    check("pop_base_fp", fp, exp_fp);
    check("pop_base_err", {15'd0, fp_err}, {15'd0, exp_err});
    check("pop_base_pc", pc, 16'h0032);
    push_up = 1'b1;
    step();
    exp_fp = exp_fp + 16'd1;
    check("push_fp", fp, exp_fp);
    check("push_err", {15'd0, fp_err}, {15'd0, exp_err});
    check("push_pc", pc, 16'h0033);

    // Halt: both pc controls low.
    move_fp = 1'b0; pc_sload = 1'b1; new_pc = 16'h0042;
    step();
    check("ld_0042", pc, 16'h0042);
    pc_sload = 1'b0; cnt_en = 1'b0;
    step();
    check("halt_flag", {15'd0, halted}, 16'd1);
    check("halt_fv", {15'd0, fetch_valid}, 16'd0);
    check("halt_pc", pc, 16'h0042);
    pc_sload = 1'b1; new_pc = 16'h0000; move_fp = 1'b1; push_up = 1'b1;
    step();
    check("halt_hold_pc", pc, 16'h0042);
    check("halt_hold_fp", fp, exp_fp);
    check("halt_stay", {15'd0, halted}, 16'd1);

    // Reset with stall high, then boot held by stall.
    reset = 1'b1; stall = 1'b1;
    step();
    check("rst2_halt", {15'd0, halted}, 16'd0);
    check("rst2_pc", pc, 16'h0010);
    check("rst2_fp", fp, 16'hFF00);
    check("rst2_err", {15'd0, fp_err}, 16'd0);
    reset = 1'b0; pc_sload = 1'b0; move_fp = 1'b0; cnt_en = 1'b1;
    step();
    check("boot_stall_fv", {15'd0, fetch_valid}, 16'd0);
    check("boot_stall_pc", pc, 16'h0010);
    stall = 1'b0;
    step();
    check("boot_rel_fv", {15'd0, fetch_valid}, 16'd1);
    check("boot_rel_pc", pc, 16'h0010);
    step();
    check("boot_rel_inc", pc, 16'h0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
